// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl
//   Memory-mapped CPU front end for the byte-level UART core. Bytes written by
//   the CPU are queued in a TX FIFO and handed to the core transmitter; bytes
//   from the core receiver are queued in an RX FIFO and read back by the CPU.
//   Register reads have one cycle of latency.
//
//   Register map (mmio_addr[3:2]):
//     0 STATUS  R/W1C  [0] tx_not_full [1] rx_not_empty [2] rx_overrun (sticky)
//                      [3] tx_drop (sticky) [11:8] rx_count [15:12] tx_count
//     1 RX_DATA RO     head byte; a read of a non-empty FIFO pops it
//     2 TX_DATA WO     pushes wdata[7:0]; dropped (tx_drop set) when full
//     3 CTRL    R/W    [0] rx_irq_en [1] tx_irq_en
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   mmio_addr/we/re     CPU access (addr[1:0] ignored)
//   mmio_wdata          write data
//   mmio_rdata          registered read data, valid the cycle after mmio_re
//   core_tx_*           ready/valid byte stream towards the core transmitter
//   core_rx_*           ready/valid byte stream from the core receiver
//   irq                 level interrupt
module uart_mmio_ctrl #(
    parameter int RX_DEPTH = 4,
    parameter int TX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  mmio_addr,
    input  logic        mmio_we,
    input  logic        mmio_re,
    input  logic [31:0] mmio_wdata,
    output logic [31:0] mmio_rdata,
    output logic [7:0]  core_tx_data,
    output logic        core_tx_valid,
    input  logic        core_tx_ready,
    input  logic [7:0]  core_rx_data,
    input  logic        core_rx_valid,
    output logic        core_rx_ready,
    output logic        irq
);

    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int RX_CW = RX_AW + 1;
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int TX_CW = TX_AW + 1;

    localparam logic [1:0] REG_STATUS  = 2'd0;
    localparam logic [1:0] REG_RX_DATA = 2'd1;
    localparam logic [1:0] REG_TX_DATA = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    // FIFO storage and state
    logic [7:0]       rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] rx_rd_ptr_reg, rx_wr_ptr_reg;
    logic [RX_CW-1:0] rx_count_reg, rx_count_next;

    logic [7:0]       tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] tx_rd_ptr_reg, tx_wr_ptr_reg;
    logic [TX_CW-1:0] tx_count_reg, tx_count_next;

    logic             rx_overrun_reg, rx_overrun_next;
    logic             tx_drop_reg, tx_drop_next;
    logic [1:0]       ctrl_reg;
    logic [31:0]      rdata_reg, rdata_next;

    // Address decode
    logic [1:0] addr_sel;
    logic       wr_status, wr_tx_data, wr_ctrl, rd_rx_data;

    assign addr_sel   = mmio_addr[3:2];
    assign wr_status  = mmio_we & (addr_sel == REG_STATUS);
    assign wr_tx_data = mmio_we & (addr_sel == REG_TX_DATA) & ~rst;
    assign wr_ctrl    = mmio_we & (addr_sel == REG_CTRL);
    assign rd_rx_data = mmio_re & (addr_sel == REG_RX_DATA);

    // Low address bits and upper write-data bits carry no information here.
    logic unused_bits;
    assign unused_bits = ^{mmio_addr[1:0], mmio_wdata[31:8]};

    // RX path
    logic rx_empty, rx_full, rx_pop, rx_push, rx_overrun_set;

    assign rx_empty = (rx_count_reg == '0);
    assign rx_full  = (rx_count_reg == RX_CW'(RX_DEPTH));
    assign rx_pop   = rd_rx_data & ~rx_empty & ~rst;
    // A full FIFO still accepts a byte when the CPU frees a slot this cycle.
    assign rx_push        = core_rx_valid & ~rst & (~rx_full | rx_pop);
    assign rx_overrun_set = core_rx_valid & ~rst & rx_full & ~rx_pop;

    assign core_rx_ready = ~rst;

    // TX path
    logic tx_empty, tx_full, tx_pop, tx_push, tx_drop_set;

    assign tx_empty      = (tx_count_reg == '0);
    assign tx_full       = (tx_count_reg == TX_CW'(TX_DEPTH));
    assign core_tx_valid = ~rst & ~tx_empty;
    assign core_tx_data  = tx_mem[tx_rd_ptr_reg];
    assign tx_pop        = core_tx_valid & core_tx_ready;
    assign tx_push       = wr_tx_data & (~tx_full | tx_pop);
    assign tx_drop_set   = wr_tx_data & tx_full & ~tx_pop;

    always_comb begin
        rx_count_next = rx_count_reg;
        case ({rx_push, rx_pop})
            2'b10:   rx_count_next = rx_count_reg + 1'b1;
            2'b01:   rx_count_next = rx_count_reg - 1'b1;
            default: rx_count_next = rx_count_reg;
        endcase
    end

    always_comb begin
        tx_count_next = tx_count_reg;
        case ({tx_push, tx_pop})
            2'b10:   tx_count_next = tx_count_reg + 1'b1;
            2'b01:   tx_count_next = tx_count_reg - 1'b1;
            default: tx_count_next = tx_count_reg;
        endcase
    end

    // Sticky flags: a new event in the same cycle as a W1C clear wins, so no
    // event is ever lost.
    always_comb begin
        rx_overrun_next = rx_overrun_reg;
        tx_drop_next    = tx_drop_reg;
        if (wr_status && mmio_wdata[2]) begin
            rx_overrun_next = 1'b0;
        end
        if (wr_status && mmio_wdata[3]) begin
            tx_drop_next = 1'b0;
        end
        if (rx_overrun_set) begin
            rx_overrun_next = 1'b1;
        end
        if (tx_drop_set) begin
            tx_drop_next = 1'b1;
        end
    end

    // Read mux sees only pre-update state, so a simultaneous write is not
    // visible in the returned value.
    logic [31:0] status_word;

    always_comb begin
        status_word        = '0;
        status_word[0]     = ~tx_full;
        status_word[1]     = ~rx_empty;
        status_word[2]     = rx_overrun_reg;
        status_word[3]     = tx_drop_reg;
        status_word[11:8]  = 4'(rx_count_reg);
        status_word[15:12] = 4'(tx_count_reg);
    end

    always_comb begin
        rdata_next = rdata_reg;
        if (mmio_re) begin
            case (addr_sel)
                REG_STATUS:  rdata_next = status_word;
                REG_RX_DATA: rdata_next = rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rd_ptr_reg]};
                REG_TX_DATA: rdata_next = 32'd0;
                default:     rdata_next = {30'd0, ctrl_reg};
            endcase
        end
    end

    // FIFO storage has no reset; validity is tracked by the counts.
    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr_reg] <= core_rx_data;
        end
        if (tx_push) begin
            tx_mem[tx_wr_ptr_reg] <= mmio_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_rd_ptr_reg  <= '0;
            rx_wr_ptr_reg  <= '0;
            rx_count_reg   <= '0;
            tx_rd_ptr_reg  <= '0;
            tx_wr_ptr_reg  <= '0;
            tx_count_reg   <= '0;
            rx_overrun_reg <= 1'b0;
            tx_drop_reg    <= 1'b0;
            ctrl_reg       <= 2'b00;
            rdata_reg      <= '0;
        end else begin
            // Pointers wrap naturally because depths are powers of two.
            if (rx_pop) begin
                rx_rd_ptr_reg <= rx_rd_ptr_reg + 1'b1;
            end
            if (rx_push) begin
                rx_wr_ptr_reg <= rx_wr_ptr_reg + 1'b1;
            end
            if (tx_pop) begin
                tx_rd_ptr_reg <= tx_rd_ptr_reg + 1'b1;
            end
            if (tx_push) begin
                tx_wr_ptr_reg <= tx_wr_ptr_reg + 1'b1;
            end
            rx_count_reg   <= rx_count_next;
            tx_count_reg   <= tx_count_next;
            rx_overrun_reg <= rx_overrun_next;
            tx_drop_reg    <= tx_drop_next;
            if (wr_ctrl) begin
                ctrl_reg <= mmio_wdata[1:0];
            end
            rdata_reg <= rdata_next;
        end
    end

    assign mmio_rdata = rdata_reg;

    // Built from registered state; gated so it reads 0 throughout reset.
    assign irq = ~rst & ((ctrl_reg[0] & ~rx_empty) | (ctrl_reg[1] & tx_empty));

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// tb_uart_mmio_ctrl
//   Randomised plus directed stimulus for uart_mmio_ctrl. The driver keeps a
//   queue-based model of the register block and pushes expected responses into
//   scoreboard queues; an independent monitor compares them against the DUT.
module tb_uart_mmio_ctrl;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  mmio_addr;
    logic        mmio_we;
    logic        mmio_re;
    logic [31:0] mmio_wdata;
    logic [31:0] mmio_rdata;
    logic [7:0]  core_tx_data;
    logic        core_tx_valid;
    logic        core_tx_ready;
    logic [7:0]  core_rx_data;
    logic        core_rx_valid;
    logic        core_rx_ready;
    logic        irq;

    uart_mmio_ctrl #(.RX_DEPTH(D), .TX_DEPTH(D)) dut (
        .clk           (clk),
        .rst           (rst),
        .mmio_addr     (mmio_addr),
        .mmio_we       (mmio_we),
        .mmio_re       (mmio_re),
        .mmio_wdata    (mmio_wdata),
        .mmio_rdata    (mmio_rdata),
        .core_tx_data  (core_tx_data),
        .core_tx_valid (core_tx_valid),
        .core_tx_ready (core_tx_ready),
        .core_rx_data  (core_rx_data),
        .core_rx_valid (core_rx_valid),
        .core_rx_ready (core_rx_ready),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Scoreboard queues
    typedef struct {
        bit irq;
        bit txv;
        bit rxr;
    } stat_t;
    stat_t       stat_q[$];
    logic [31:0] rd_q[$];
    logic [7:0]  tx_exp_q[$];

    // Reference model: plain queues plus flag bits
    logic [7:0] m_rx[$];
    logic [7:0] m_tx[$];
    bit         m_ovr;
    bit         m_drop;
    logic [1:0] m_ctrl;

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s        = 32'd0;
        s[0]     = (m_tx.size() < D);
        s[1]     = (m_rx.size() != 0);
        s[2]     = m_ovr;
        s[3]     = m_drop;
        s[11:8]  = 4'(m_rx.size());
        s[15:12] = 4'(m_tx.size());
        return s;
    endfunction

    function automatic bit m_irq();
        return (m_ctrl[0] && m_rx.size() != 0) || (m_ctrl[1] && m_tx.size() == 0);
    endfunction

    // One clock cycle of stimulus; model is advanced to post-edge state.
    task automatic cycle(input bit re, input bit we, input logic [3:0] addr,
                         input logic [31:0] wd, input bit rxv,
                         input logic [7:0] rxd, input bit txr);
        logic [31:0] rv;
        int          rx_n;
        int          tx_n;
        bit          pop_rx;
        bit          hs_tx;
        bit          ovr_set;
        bit          drop_set;
        rst           = 1'b0;
        mmio_re       = re;
        mmio_we       = we;
        mmio_addr     = addr;
        mmio_wdata    = wd;
        core_rx_valid = rxv;
        core_rx_data  = rxd;
        core_tx_ready = txr;
        stat_q.push_back('{m_irq(), m_tx.size() != 0, 1'b1});
        rx_n     = m_rx.size();
        tx_n     = m_tx.size();
        ovr_set  = 1'b0;
        drop_set = 1'b0;
        case (addr[3:2])
            2'd0:    rv = m_status();
            2'd1:    rv = (rx_n > 0) ? {24'd0, m_rx[0]} : 32'd0;
            2'd2:    rv = 32'd0;
            default: rv = {30'd0, m_ctrl};
        endcase
        if (re) rd_q.push_back(rv);
        pop_rx = re && (addr[3:2] == 2'd1) && (rx_n > 0);
        if (pop_rx) void'(m_rx.pop_front());
        if (rxv) begin
            if (rx_n < D || pop_rx) m_rx.push_back(rxd);
            else ovr_set = 1'b1;
        end
        hs_tx = (tx_n > 0) && txr;
        if (hs_tx) tx_exp_q.push_back(m_tx.pop_front());
        if (we && addr[3:2] == 2'd2) begin
            if (tx_n < D || hs_tx) m_tx.push_back(wd[7:0]);
            else drop_set = 1'b1;
        end
        if (we && addr[3:2] == 2'd0) begin
            if (wd[2]) m_ovr = 1'b0;
            if (wd[3]) m_drop = 1'b0;
        end
        if (ovr_set) m_ovr = 1'b1;
        if (drop_set) m_drop = 1'b1;
        if (we && addr[3:2] == 2'd3) m_ctrl = wd[1:0];
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            rst           = 1'b1;
            mmio_re       = 1'b0;
            mmio_we       = 1'b0;
            mmio_addr     = 4'd0;
            mmio_wdata    = 32'd0;
            core_rx_valid = 1'b0;
            core_rx_data  = 8'd0;
            core_tx_ready = 1'b0;
            stat_q.push_back('{1'b0, 1'b0, 1'b0});
            m_rx.delete();
            m_tx.delete();
            m_ovr  = 1'b0;
            m_drop = 1'b0;
            m_ctrl = 2'b00;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [3:0] a);
        cycle(1'b1, 1'b0, a, 32'd0, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        cycle(1'b0, 1'b1, a, d, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic idle(input bit txr);
        cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 8'd0, txr);
    endtask

    task automatic rx_push(input logic [7:0] b);
        cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, b, 1'b0);
    endtask

    // Monitor
    bit    re_d = 1'b0;
    stat_t s_cur;

    always @(posedge clk) re_d <= mmio_re && !rst;

    initial begin
        forever begin
            @(negedge clk);
            if (stat_q.size() != 0) begin
                s_cur = stat_q.pop_front();
                checks++;
                if ({irq, core_tx_valid, core_rx_ready} !== {s_cur.irq, s_cur.txv, s_cur.rxr}) begin
                    failures++;
                    $display("FAIL status_pins irq/tx_valid/rx_ready got %b%b%b expected %b%b%b at %0t",
                             irq, core_tx_valid, core_rx_ready, s_cur.irq, s_cur.txv, s_cur.rxr, $time);
                end
            end
            if (re_d) begin
                checks++;
                if (rd_q.size() == 0) begin
                    failures++;
                    $display("FAIL rdata unexpected read response got %h at %0t", mmio_rdata, $time);
                end else begin
                    logic [31:0] e;
                    e = rd_q.pop_front();
                    if (mmio_rdata !== e) begin
                        failures++;
                        $display("FAIL rdata got %h expected %h at %0t", mmio_rdata, e, $time);
                    end
                end
            end
            if (core_tx_valid === 1'b1 && core_tx_ready === 1'b1) begin
                checks++;
                if (tx_exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL tx_byte unexpected handshake got %h at %0t", core_tx_data, $time);
                end else begin
                    logic [7:0] eb;
                    eb = tx_exp_q.pop_front();
                    if (core_tx_data !== eb) begin
                        failures++;
                        $display("FAIL tx_byte got %h expected %h at %0t", core_tx_data, eb, $time);
                    end
                end
            end
        end
    end

    initial begin
        rst           = 1'b1;
        mmio_re       = 1'b0;
        mmio_we       = 1'b0;
        mmio_addr     = 4'd0;
        mmio_wdata    = 32'd0;
        core_rx_valid = 1'b0;
        core_rx_data  = 8'd0;
        core_tx_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset(3);

        // Reset state via STATUS
        rd(4'h0);
        idle(1'b0);

        // Two TX bytes held, then drained back to back
        wr(4'h8, 32'h41);
        wr(4'h8, 32'h42);
        rd(4'h0);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // TX overflow and W1C of tx_drop
        for (int i = 0; i < 5; i++) wr(4'h8, 32'h50 + i);
        rd(4'h0);
        wr(4'h0, 32'h8);
        rd(4'h0);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // RX overflow, reads past empty
        for (int i = 0; i < 5; i++) rx_push(8'h10 + 8'(i));
        rd(4'h0);
        for (int i = 0; i < 5; i++) rd(4'h4);
        rd(4'h0);
        wr(4'h0, 32'h4);

        // RX full with simultaneous pop and push
        for (int i = 0; i < 4; i++) rx_push(8'h20 + 8'(i));
        cycle(1'b1, 1'b0, 4'h4, 32'd0, 1'b1, 8'h99, 1'b0);
        rd(4'h0);
        for (int i = 0; i < 4; i++) rd(4'h4);

        // TX full with simultaneous core pop and CPU write
        for (int i = 0; i < 4; i++) wr(4'h8, 32'h60 + i);
        cycle(1'b0, 1'b1, 4'h8, 32'h77, 1'b0, 8'd0, 1'b1);
        rd(4'h0);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Interrupts
        wr(4'hC, 32'h1);
        rx_push(8'h33);
        idle(1'b0);
        rd(4'h4);
        idle(1'b0);
        wr(4'hC, 32'h2);
        rd(4'hC);
        idle(1'b0);

        // Reset mid-stream
        wr(4'h8, 32'hAA);
        rx_push(8'hBB);
        wr(4'hC, 32'h3);
        do_reset(1);
        rd(4'h0);
        idle(1'b0);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset(2);
            end else begin
                cycle(($urandom % 3) == 0, ($urandom % 3) == 0, 4'($urandom),
                      $urandom, ($urandom % 3) == 0, 8'($urandom), ($urandom % 2) == 1);
            end
        end
        for (int i = 0; i < 8; i++) idle(1'b1);

        checks++;
        if (rd_q.size() != 0 || tx_exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending reads %0d tx bytes %0d expected 0 0",
                     rd_q.size(), tx_exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_mmio_ctrl.md
Name: uart_mmio_ctrl

Overview:
- CPU-side memory-mapped controller that sits on the byte-level ready/valid interface of the UART core.
- Sources bytes to the core transmit input and sinks bytes from the core receive output.
- Buffers each direction in a small FIFO and exposes status, data and control registers to the AMA-RISCV load/store path with 1-cycle read latency.

Parameters:
- RX_DEPTH, 4, receive FIFO entries; power of two, 2..8.
- TX_DEPTH, 4, transmit FIFO entries; power of two, 2..8.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- mmio_addr  input  4  byte offset within UART window (bits [3:2] used)
- mmio_we  input  1  write strobe, one access per cycle
- mmio_re  input  1  read strobe
- mmio_wdata  input  32  write data
- mmio_rdata  output  32  registered read data, valid cycle after mmio_re
- core_tx_data  output  8  byte to core transmitter
- core_tx_valid  output  1  TX FIFO not empty
- core_tx_ready  input  1  core transmitter accepts byte
- core_rx_data  input  8  byte from core receiver
- core_rx_valid  input  1  core receiver has byte
- core_rx_ready  output  1  controller accepts byte
- irq  output  1  level interrupt

Behaviour:
- Register map, offset [3:2]:
  - 0x0 STATUS (R/W1C):
    - bit0 tx_not_full
    - bit1 rx_not_empty
    - bit2 rx_overrun (sticky)
    - bit3 tx_drop (sticky)
    - [11:8] rx_count
    - [15:12] tx_count
    - other bits 0
    - Write 1 to bit2/bit3 clears that bit; other bits read-only.
  - 0x4 RX_DATA (RO): read returns {24'b0, head}. A read with FIFO non-empty pops the entry. A read with FIFO empty returns 0 and does not pop. Writes are ignored.
  - 0x8 TX_DATA (WO): write pushes mmio_wdata[7:0]. A write with FIFO full drops the byte and sets tx_drop. Reads return 0.
  - 0xC CTRL (R/W): bit0 rx_irq_en, bit1 tx_irq_en; other bits read 0, writes to them ignored.
  - mmio_we and mmio_re both high: write takes effect; read returns pre-write register value.
- Read path:
  - mmio_rdata registered; updated only on cycles with mmio_re; holds its value otherwise.
  - Read side effects (RX pop) occur in the same cycle as mmio_re.
- RX path:
  - core_rx_ready = 1 whenever not in reset; each cycle with core_rx_valid=1 is one handshake.
  - Push when FIFO not full, or when full and a CPU pop occurs in the same cycle (count unchanged).
  - Full with no pop: byte discarded, rx_overrun set the next cycle.
- TX path:
  - core_tx_valid = tx_count != 0; core_tx_data = TX head; pop on core_tx_valid & core_tx_ready.
  - Full with a core pop and a CPU write in the same cycle: accepted, count unchanged, no drop.
  - Empty with a CPU write: byte visible on core_tx_valid the next cycle, never the same cycle.
- FIFOs:
  - Circular buffers with read/write pointers of log2(DEPTH) bits, wrapping modulo DEPTH.
  - Separate count register of log2(DEPTH)+1 bits.
  - Order strictly FIFO.
- irq = (rx_irq_en & rx_count!=0) | (tx_irq_en & tx_count==0); derived from registered state only.
- Reset:
  - FIFOs empty, pointers/counts 0, sticky bits 0, CTRL 0.
  - mmio_rdata 0, core_tx_valid 0, core_rx_ready 0, irq 0.
  - Reset mid-transfer discards all buffered bytes; no handshake completes in a reset cycle.
- Unmapped behaviour: none; all four offsets decoded; mmio_addr[1:0] ignored.

Test Plan:
- Reset, then read STATUS -> mmio_rdata=0x00000001 next cycle (tx_not_full=1); irq=0; core_tx_valid=0.
- Write TX_DATA 0x41, 0x42 with core_tx_ready=0 -> tx_count=2. Raise core_tx_ready -> core_tx_data 0x41 then 0x42 on consecutive cycles; core_tx_valid drops after.
- With core_tx_ready=0, write 5 bytes into TX_DEPTH=4 -> 5th byte dropped, STATUS bit3=1, tx_count=4. Write STATUS 0x8 -> bit3 clears.
- Push 0x10..0x14 via core_rx_valid with no CPU reads -> rx_count=4, rx_overrun=1. RX_DATA reads return 0x10,0x11,0x12,0x13, then 0 with no pop.
- RX full, CPU RX_DATA read and core push 0x99 same cycle -> no overrun, count stays 4, 0x99 read last. TX analog: full, core pop and CPU write same cycle -> no drop.
- CTRL=0x1, push one RX byte -> irq=1 next cycle, 0 after RX_DATA read. CTRL=0x2 with TX empty -> irq=1. Assert rst mid-stream -> all counts 0, irq=0.
